operand_fetch_stage: RTL and testbench

//   Register-read pipeline stage between instruction decode and execute.

---
 rtl/operand_fetch_stage.sv | 121 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Register-read stage: bypassed operand resolution, load-use
// stall detection and a valid/ready pipeline register to execute.
module operand_fetch_stage #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [2:0]      dec_rs1,
    input  logic [2:0]      dec_rs2,
    input  logic            dec_use1,
    input  logic            dec_use2,
    input  logic [2:0]      dec_rd,
    input  logic            dec_rd_we,
    input  logic [OP_W-1:0] dec_op,
    input  logic [7:0]      dec_imm,
    output logic [2:0]      rf_read_reg1,
    output logic [2:0]      rf_read_reg2,
    input  logic [7:0]      rf_read_data1,
    input  logic [7:0]      rf_read_data2,
    input  logic            wb_write_reg_en,
    input  logic [2:0]      wb_write_reg,
    input  logic [7:0]      wb_write_data,
    input  logic            ex_fwd_valid,
    input  logic            ex_fwd_pending,
    input  logic [2:0]      ex_fwd_reg,
    input  logic [7:0]      ex_fwd_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [7:0]      ex_a,
    output logic [7:0]      ex_b,
    output logic [2:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [OP_W-1:0] ex_op,
    output logic [7:0]      ex_imm,
    output logic [CNT_W-1:0] stall_count
);

    logic            valid_q, valid_d;
    logic [7:0]      a_q, b_q, imm_q;
    logic [2:0]      rd_q;
    logic            we_q;
    logic [OP_W-1:0] op_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]      opa, opb;
    logic            hazard, load;

    assign rf_read_reg1 = dec_rs1;
    assign rf_read_reg2 = dec_rs2;

    // Operand bypass: execute result beats writeback beats register file
    always_comb begin
        opa = rf_read_data1;
        opb = rf_read_data2;
        if (ex_fwd_valid && ex_fwd_reg == dec_rs1)
            opa = ex_fwd_data;
        else if (wb_write_reg_en && wb_write_reg == dec_rs1)
            opa = wb_write_data;
        if (ex_fwd_valid && ex_fwd_reg == dec_rs2)
            opb = ex_fwd_data;
        else if (wb_write_reg_en && wb_write_reg == dec_rs2)
            opb = wb_write_data;
    end

    // Load-use hazard, handshake and next-state of valid and counter
    always_comb begin
        hazard = ex_fwd_pending &&
                 ((dec_use1 && ex_fwd_reg == dec_rs1) ||
                  (dec_use2 && ex_fwd_reg == dec_rs2));
        dec_ready = !flush && !hazard && (!valid_q || ex_ready);
        load = dec_valid && dec_ready;
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (load)
            valid_d = 1'b1;
        else if (ex_ready)
            valid_d = 1'b0;
        cnt_d = cnt_q;
        if (dec_valid && hazard && !flush && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Pipeline register; payload only changes on an accepted instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (load) begin
                a_q   <= opa;
                b_q   <= opb;
                rd_q  <= dec_rd;
                we_q  <= dec_rd_we;
                op_q  <= dec_op;
                imm_q <= dec_imm;
            end
        end
    end

    assign ex_valid    = valid_q;
    assign ex_a        = a_q;
    assign ex_b        = b_q;
    assign ex_rd       = rd_q;
    assign ex_rd_we    = we_q;
    assign ex_op       = op_q;
    assign ex_imm      = imm_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: scoreboard of accepted bundles
// plus directed checks of stalls, backpressure, flush and reset.
module tb_operand_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_ready;
    logic [2:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_use1, dec_use2, dec_rd_we;
    logic [3:0] dec_op;
    logic [7:0] dec_imm;
    logic [2:0] rf_read_reg1, rf_read_reg2;
    logic [7:0] rf_read_data1, rf_read_data2;
    logic       wb_write_reg_en;
    logic [2:0] wb_write_reg;
    logic [7:0] wb_write_data;
    logic       ex_fwd_valid, ex_fwd_pending;
    logic [2:0] ex_fwd_reg;
    logic [7:0] ex_fwd_data;
    logic       flush;
    logic       ex_valid, ex_ready;
    logic [7:0] ex_a, ex_b, ex_imm;
    logic [2:0] ex_rd;
    logic       ex_rd_we;
    logic [3:0] ex_op;
    logic [7:0] stall_count;

    logic [7:0] rf [8];
    assign rf_read_data1 = rf[rf_read_reg1];
    assign rf_read_data2 = rf[rf_read_reg2];

    always #5 clk = ~clk;

    operand_fetch_stage #(.OP_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use1(dec_use1), .dec_use2(dec_use2),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
        .dec_op(dec_op), .dec_imm(dec_imm),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_write_reg_en(wb_write_reg_en), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_pending(ex_fwd_pending),
        .ex_fwd_reg(ex_fwd_reg), .ex_fwd_data(ex_fwd_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_op(ex_op), .ex_imm(ex_imm), .stall_count(stall_count)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] rd;
        logic       we;
        logic [3:0] op;
        logic [7:0] imm;
    } bnd_t;

    bnd_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [2:0] rs);
        if (ex_fwd_valid && ex_fwd_reg == rs) return ex_fwd_data;
        if (wb_write_reg_en && wb_write_reg == rs) return wb_write_data;
        return rf[rs];
    endfunction

    function automatic bnd_t model();
        bnd_t e;
        e.a   = pick(dec_rs1);
        e.b   = pick(dec_rs2);
        e.rd  = dec_rd;
        e.we  = dec_rd_we;
        e.op  = dec_op;
        e.imm = dec_imm;
        return e;
    endfunction

    task automatic cmp_bnd(input string tag, input bnd_t e);
        check({tag, "_a"},   ex_a, e.a);
        check({tag, "_b"},   ex_b, e.b);
        check({tag, "_rd"},  ex_rd, e.rd);
        check({tag, "_we"},  ex_rd_we, e.we);
        check({tag, "_op"},  ex_op, e.op);
        check({tag, "_imm"}, ex_imm, e.imm);
    endtask

    // Scoreboard: push on accept, pop on execute handshake
    always @(negedge clk) begin
        bnd_t e;
        if (!rst) begin
            q.delete();
        end else begin
            if (ex_valid && ex_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    cmp_bnd("sb", e);
                end
            end else if (ex_valid && flush && q.size() > 0) begin
                e = q.pop_front();
            end
            if (dec_valid && dec_ready) q.push_back(model());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0;
        dec_use1 = 0; dec_use2 = 0; dec_rd = 0; dec_rd_we = 0;
        dec_op = 0; dec_imm = 0;
        wb_write_reg_en = 0; wb_write_reg = 0; wb_write_data = 0;
        ex_fwd_valid = 0; ex_fwd_pending = 0;
        ex_fwd_reg = 0; ex_fwd_data = 0;
        flush = 0;
    endtask

    task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic [3:0] op,
                         input logic [7:0] imm);
        dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_use1 = 1; dec_use2 = 1; dec_rd = rd; dec_rd_we = 1;
        dec_op = op; dec_imm = imm;
    endtask

    bnd_t expA;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'(8'h10 * i + 1);
        idle();
        rst = 0;
        ex_ready = 1;
        tick(); tick();
        @(negedge clk);
        check("rst_valid", ex_valid, 0);
        check("rst_a", ex_a, 0);
        check("rst_b", ex_b, 0);
        check("rst_op", ex_op, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_cnt", stall_count, 0);
        tick();
        rst = 1;

        // RF path
        rf[3] = 8'h5A;
        issue(3, 3, 1, 4'h5, 8'h77);
        @(negedge clk);
        check("rf_addr1", rf_read_reg1, 3);
        check("rdy_idle", dec_ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("rf_valid", ex_valid, 1);
        check("rf_a", ex_a, 8'h5A);
        check("rf_b", ex_b, 8'h5A);
        tick();

        // Bypass priority
        rf[2] = 8'h11;
        issue(2, 5, 2, 4'h3, 8'h01);
        wb_write_reg_en = 1; wb_write_reg = 2; wb_write_data = 8'h22;
        ex_fwd_valid = 1; ex_fwd_reg = 2; ex_fwd_data = 8'h33;
        @(negedge clk);
        tick();
        ex_fwd_valid = 0;
        @(negedge clk);
        check("pri_fwd", ex_a, 8'h33);
        tick();
        wb_write_reg_en = 0;
        @(negedge clk);
        check("pri_wb", ex_a, 8'h22);
        tick();
        idle();
        @(negedge clk);
        check("pri_rf", ex_a, 8'h11);
        tick();

        // Load-use stall
        ex_fwd_pending = 1; ex_fwd_reg = 4; ex_fwd_data = 8'h9C;
        issue(1, 4, 6, 4'h7, 8'h42);
        dec_use1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lu_rdy", dec_ready, 0);
            tick();
        end
        @(negedge clk);
        check("lu_cnt3", stall_count, 3);
        tick();
        ex_fwd_pending = 0; ex_fwd_valid = 1;
        @(negedge clk);
        check("lu_accept", dec_ready, 1);
        tick();
        ex_fwd_valid = 0;
        dec_valid = 0;
        @(negedge clk);
        check("lu_b", ex_b, 8'h9C);
        tick();
        ex_fwd_pending = 1;
        dec_valid = 1; dec_use2 = 0;
        @(negedge clk);
        check("nouse_rdy", dec_ready, 1);
        tick();
        idle();
        tick();
        @(negedge clk);
        check("nouse_cnt", stall_count, 4);
        tick();

        // Backpressure
        ex_ready = 0;
        issue(6, 7, 3, 4'hA, 8'hA5);
        @(negedge clk);
        expA = model();
        tick();
        issue(1, 2, 4, 4'hB, 8'hB6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdy", dec_ready, 0);
            check("bp_valid", ex_valid, 1);
            cmp_bnd("bp_hold", expA);
            tick();
        end
        ex_ready = 1;
        @(negedge clk);
        check("bp_release", dec_ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("bp_b_imm", ex_imm, 8'hB6);
        tick();
        tick();

        // Flush
        ex_ready = 0;
        issue(0, 1, 5, 4'h1, 8'hC1);
        tick();
        issue(2, 3, 6, 4'h2, 8'hD2);
        flush = 1;
        @(negedge clk);
        check("fl_rdy", dec_ready, 0);
        tick();
        idle();
        @(negedge clk);
        check("fl_valid", ex_valid, 0);
        tick();
        ex_ready = 1;

        // Reset mid-stall
        ex_fwd_pending = 1; ex_fwd_reg = 2;
        issue(2, 0, 1, 4'h4, 8'h10);
        tick(); tick(); tick();
        @(negedge clk);
        check("ms_cnt", stall_count, 7);
        tick();
        rst = 0;
        tick();
        @(negedge clk);
        check("ms_rst_cnt", stall_count, 0);
        check("ms_rst_valid", ex_valid, 0);
        tick();
        rst = 1;

        // Saturation; hazard still held from above
        for (int i = 0; i < 300; i++) tick();
        @(negedge clk);
        check("sat_cnt", stall_count, 255);
        tick();

        idle();
        tick(); tick(); tick();
        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
